uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arb_if.sv | 34 +++
 rtl/uart_rr_arb2.sv | 42 ++++
 rtl/uart_tx_arb.sv | 117 +++++++++++
 tb/tb_uart_tx_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
//   uart_state_e         : arbiter FSM state encoding (2 bits)
//   DEFAULT_BUSY_TIMEOUT : default cycles to wait for the UART busy flag
//   UART_BYTE_W          : width of one UART byte
package uart_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int DEFAULT_BUSY_TIMEOUT = 16;
  localparam int CNT_W                = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: bundle of the requester handshakes and the UART-side
// signals of the transmit arbiter.
//   req0_*/req1_*   : valid/data from requesters, ready back to them
//   transmit/tx_byte: start pulse and byte toward the UART
//   is_transmitting : UART busy flag
//   tx_done/tx_err  : completion / busy-timeout pulses, tx_id owner index
// Modports: slave = arbiter side, master = requesters + UART side.
interface uart_tx_arb_if;
  import uart_pkg::*;

  logic                   req0_valid;
  logic [UART_BYTE_W-1:0] req0_data;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [UART_BYTE_W-1:0] req1_data;
  logic                   req1_ready;
  logic                   transmit;
  logic [UART_BYTE_W-1:0] tx_byte;
  logic                   is_transmitting;
  logic                   tx_done;
  logic                   tx_id;
  logic                   tx_err;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, is_transmitting,
    output req0_ready, req1_ready, transmit, tx_byte, tx_done, tx_id, tx_err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, is_transmitting,
    input  req0_ready, req1_ready, transmit, tx_byte, tx_done, tx_id, tx_err
  );

endinterface

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2: two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : grants may be issued this cycle
//   req_i    : request vector, bit N = requester N
//   gnt_o    : one-hot grant (combinational), zero when en_i is low
// last_grant resets to 1 so requester 0 wins the first contention; it only
// moves when a grant is actually issued.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
    if (gnt_o != 2'b00) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates two byte requesters onto one UART transmitter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_tx_arb_if.slave (requester handshakes, UART control,
//              completion/error pulses)
// Parameter BUSY_TIMEOUT: cycles to wait in WAIT_BUSY for the UART to
// report busy before giving up (1..255).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request while the UART is free; grants here
// START     | transmit pulse for the latched byte
// WAIT_BUSY | waiting for the UART to raise is_transmitting (timed)
// WAIT_DONE | UART busy; waiting for it to finish
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(BUSY_TIMEOUT);

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic                   tx_id_q, tx_id_d;
  logic                   tx_done_q, tx_done_d;
  logic                   tx_err_q, tx_err_d;
  logic                   grant_en;
  logic [1:0]             gnt;

  // Grants are held off during a done/err pulse so the next grant lands no
  // earlier than the cycle after it.
  assign grant_en = (state_q == ST_IDLE) && !rst && !bus.is_transmitting &&
                    !tx_done_q && !tx_err_q;

  uart_rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (grant_en),
    .req_i ({bus.req1_valid, bus.req0_valid}),
    .gnt_o (gnt)
  );

  // Saturating increment so the counter never wraps.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    tx_id_d   = tx_id_q;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          tx_id_d   = gnt[1];
          tx_byte_d = gnt[1] ? bus.req1_data : bus.req0_data;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.is_transmitting) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_C) begin
            tx_err_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.is_transmitting) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_byte_q <= '0;
      tx_id_q   <= 1'b0;
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      tx_id_q   <= tx_id_d;
      tx_done_q <= tx_done_d;
      tx_err_q  <= tx_err_d;
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.transmit   = (state_q == ST_START);
  assign bus.tx_byte    = tx_byte_q;
  assign bus.tx_id      = tx_id_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if bus();

  uart_tx_arb #(.BUSY_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       id;
    logic [7:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_gnt;
  } vec_t;
  vec_t vecs[8];

  // UART model: busy rises busy_delay cycles after transmit, held busy_hold cycles
  int   busy_delay = 2;
  int   busy_hold  = 10;
  bit   busy_never = 1'b0;
  bit   force_busy = 1'b0;
  logic uart_busy  = 1'b0;
  int   m_phase    = 0;
  int   m_cnt      = 0;

  assign bus.is_transmitting = uart_busy | force_busy;

  always @(negedge clk) begin
    if (rst) begin
      uart_busy = 1'b0;
      m_phase   = 0;
      m_cnt     = 0;
    end else begin
      case (m_phase)
        0: if (bus.transmit && !busy_never) begin
             m_phase = 1;
             m_cnt   = busy_delay;
           end
        1: begin
             m_cnt--;
             if (m_cnt <= 0) begin
               uart_busy = 1'b1;
               m_phase   = 2;
               m_cnt     = busy_hold;
             end
           end
        default: begin
             m_cnt--;
             if (m_cnt <= 0) begin
               uart_busy = 1'b0;
               m_phase   = 0;
             end
           end
      endcase
    end
  end

  // Monitor / scoreboard
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       n_grants = 0, n_tx = 0, n_done = 0, n_err = 0;
  int       grant_cyc = 0, tx_cyc = 0, done_cyc = 0, err_cyc = 0, fall_cyc = 0;
  logic [1:0] last_gnt_vec = 2'b00;
  bit       in_flight = 1'b0;
  logic     prev_busy = 1'b0;

  always begin
    sb_t e;
    @(negedge clk);
    #1;
    if (rst) in_flight = 1'b0;
    if (bus.req0_ready || bus.req1_ready) begin
      n_grants++;
      grant_cyc    = cyc;
      last_gnt_vec = {bus.req1_ready, bus.req0_ready};
      check("ready_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
      check("ready_needs_valid",
            {31'd0, (bus.req0_ready & ~bus.req0_valid) | (bus.req1_ready & ~bus.req1_valid)}, 0);
    end
    if (bus.transmit) begin
      n_tx++;
      tx_cyc = cyc;
      check("tx_overlap", {31'd0, in_flight}, 0);
      in_flight = 1'b1;
      check("tx_latency", cyc, grant_cyc + 1);
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: got transmit byte %0h expected none", bus.tx_byte);
      end else begin
        e = sbq.pop_front();
        check("tx_byte", {24'd0, bus.tx_byte}, {24'd0, e.data});
        check("tx_id", {31'd0, bus.tx_id}, {31'd0, e.id});
      end
    end
    if (bus.tx_done) begin
      n_done++;
      done_cyc  = cyc;
      in_flight = 1'b0;
      check("done_after_fall", cyc, fall_cyc + 1);
    end
    if (bus.tx_err) begin
      n_err++;
      err_cyc   = cyc;
      in_flight = 1'b0;
    end
    if (prev_busy && !bus.is_transmitting) fall_cyc = cyc;
    prev_busy = bus.is_transmitting;
  end

  task automatic wait_grant(input int budget);
    int k0;
    int k;
    k0 = n_grants;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      if (n_grants != k0) break;
    end
    check("grant_in_budget", {31'd0, k < budget}, 1);
  endtask

  task automatic wait_finish(input int budget);
    int k0;
    int k;
    k0 = n_done + n_err;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      if (n_done + n_err != k0) break;
    end
    check("finish_in_budget", {31'd0, k < budget}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    int d0, e0, g0, dc, busy_k;

    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'h20, 2'b01};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h21, 2'b10};
    vecs[2] = '{1'b0, 1'b1, 8'h12, 8'h22, 2'b10};
    vecs[3] = '{1'b0, 1'b1, 8'h13, 8'h23, 2'b10};
    vecs[4] = '{1'b1, 1'b1, 8'h14, 8'h24, 2'b01};
    vecs[5] = '{1'b1, 1'b0, 8'h15, 8'h25, 2'b01};
    vecs[6] = '{1'b1, 1'b1, 8'h16, 8'h26, 2'b10};
    vecs[7] = '{1'b1, 1'b0, 8'h17, 8'h27, 2'b01};

    // Reset: requests pending during rst must not be acknowledged
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'hEE;
    bus.req1_data  = 8'hDD;
    g0 = 0;
    repeat (3) begin
      @(negedge clk);
      #2;
      if (bus.req0_ready || bus.req1_ready) g0++;
    end
    check("no_ready_in_reset", g0, 0);
    @(negedge clk);
    idle_reqs();
    #3 rst = 1'b0;
    #1;
    check("rst_transmit", {31'd0, bus.transmit}, 0);
    check("rst_tx_done", {31'd0, bus.tx_done}, 0);
    check("rst_tx_err", {31'd0, bus.tx_err}, 0);
    check("rst_tx_byte", {24'd0, bus.tx_byte}, 0);
    check("rst_tx_id", {31'd0, bus.tx_id}, 0);

    // Arbitration table, short UART busy window
    busy_hold = 3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req0_valid = vecs[i].v0;
      bus.req1_valid = vecs[i].v1;
      bus.req0_data  = vecs[i].d0;
      bus.req1_data  = vecs[i].d1;
      sbq.push_back('{vecs[i].exp_gnt[1], vecs[i].exp_gnt[1] ? vecs[i].d1 : vecs[i].d0});
      wait_grant(50);
      check($sformatf("vec%0d_gnt", i), {30'd0, last_gnt_vec}, {30'd0, vecs[i].exp_gnt});
      @(negedge clk);
      idle_reqs();
      wait_finish(100);
      check($sformatf("vec%0d_id_hold", i), {31'd0, bus.tx_id}, {31'd0, vecs[i].exp_gnt[1]});
    end

    // Single request, busy 2 cycles after transmit for 10 cycles
    busy_hold = 10;
    @(negedge clk);
    d0 = n_done;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hA5;
    sbq.push_back('{1'b0, 8'hA5});
    wait_grant(20);
    @(negedge clk);
    idle_reqs();
    #2;
    check("ready_one_cycle", {31'd0, bus.req0_ready}, 0);
    wait_finish(100);
    check("single_done", n_done, d0 + 1);
    check("single_id", {31'd0, bus.tx_id}, 0);
    check("single_busy_len", fall_cyc - (tx_cyc + 2), 10);

    // Contention from reset: 0,1,0,1
    do_reset();
    busy_hold = 4;
    for (int i = 0; i < 4; i++) sbq.push_back('{i[0], i[0] ? 8'h22 : 8'h11});
    g0 = n_grants;
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'h11;
    bus.req1_data  = 8'h22;
    for (int i = 0; i < 4; i++) wait_grant(100);
    @(negedge clk);
    idle_reqs();
    wait_finish(100);
    check("contention_grants", n_grants - g0, 4);

    // Busy timeout; requester keeps valid so the regrant timing is visible
    busy_never = 1'b1;
    d0 = n_done;
    sbq.push_back('{1'b0, 8'h5A});
    sbq.push_back('{1'b0, 8'h5A});
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h5A;
    wait_grant(20);
    wait_finish(100);
    check("err_timing", err_cyc, tx_cyc + 17);
    check("no_done_on_err", n_done, d0);
    wait_grant(5);
    check("regrant_after_err", grant_cyc, err_cyc + 1);
    @(negedge clk);
    idle_reqs();
    #2;
    check("err_one_cycle", {31'd0, bus.tx_err}, 0);
    wait_finish(100);
    busy_never = 1'b0;

    // Busy at idle: hold off until the flag drops, then grant that cycle
    @(negedge clk);
    force_busy     = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h3C;
    sbq.push_back('{1'b1, 8'h3C});
    g0 = n_grants;
    repeat (6) @(negedge clk);
    check("no_grant_while_busy", n_grants, g0);
    force_busy = 1'b0;
    dc = cyc;
    wait_grant(5);
    check("grant_first_free", grant_cyc, dc);
    check("busy_idle_gnt", {30'd0, last_gnt_vec}, 2);
    @(negedge clk);
    idle_reqs();
    wait_finish(100);

    // Reset while in WAIT_DONE
    busy_hold = 20;
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h77;
    sbq.push_back('{1'b0, 8'h77});
    wait_grant(20);
    @(negedge clk);
    idle_reqs();
    for (busy_k = 0; busy_k < 20; busy_k++) begin
      @(posedge clk);
      if (bus.is_transmitting) break;
    end
    check("busy_seen", {31'd0, busy_k < 20}, 1);
    repeat (2) @(posedge clk);
    d0 = n_done;
    e0 = n_err;
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_transmit", {31'd0, bus.transmit}, 0);
    check("mid_rst_tx_done", {31'd0, bus.tx_done}, 0);
    check("mid_rst_tx_err", {31'd0, bus.tx_err}, 0);
    check("mid_rst_tx_byte", {24'd0, bus.tx_byte}, 0);
    check("mid_rst_tx_id", {31'd0, bus.tx_id}, 0);
    repeat (25) @(negedge clk);
    check("mid_rst_no_done", n_done, d0);
    check("mid_rst_no_err", n_err, e0);
    busy_hold = 3;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'h44;
    bus.req1_data  = 8'h88;
    sbq.push_back('{1'b0, 8'h44});
    wait_grant(20);
    check("post_rst_winner", {30'd0, last_gnt_vec}, 1);
    @(negedge clk);
    idle_reqs();
    wait_finish(100);

    repeat (3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
